rca_operand_collector: RTL



---
 rtl/rca_operand_collector.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rca_operand_collector.sv
// Operand collector feeding the three-operand ripple-carry adder: packs a byte
// stream into (a, b, c) triples and holds each triple until the adder side takes it.
module rca_operand_collector #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  input  logic          in_first,
  output logic          in_ready,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_resync,
  output logic          err_timeout,
  output logic [CW-1:0] triple_count
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_A, S_B, S_C} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  ra, rb, ra_nxt, rb_nxt;
  logic [W-1:0]  a_nxt, b_nxt, c_nxt;
  logic          out_valid_nxt, resync_nxt, timeout_nxt;
  logic [CW-1:0] count_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          in_beat, out_beat, tmo_fire;

  // Stall only when completing a triple would overwrite one not yet accepted.
  assign in_ready = !((state == S_C) && out_valid && !out_ready);
  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    ra_nxt        = ra;
    rb_nxt        = rb;
    a_nxt         = a;
    b_nxt         = b;
    c_nxt         = c;
    out_valid_nxt = out_valid && !out_ready;
    resync_nxt    = 1'b0;
    timeout_nxt   = 1'b0;
    count_nxt     = triple_count + CW'(out_beat);
    tcnt_nxt      = tcnt;
    // An input beat in the firing cycle wins over the timeout.
    tmo_fire      = (TIMEOUT != 0) && (state != S_A) &&
                    (tcnt == TW'(TIMEOUT)) && !in_beat;

    case (state)
      S_A: begin
        if (in_beat) begin
          ra_nxt    = in_data;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (in_beat) begin
          if (in_first) begin
            ra_nxt     = in_data;
            resync_nxt = 1'b1;
          end else begin
            rb_nxt    = in_data;
            state_nxt = S_C;
          end
        end
      end
      S_C: begin
        if (in_beat) begin
          if (in_first) begin
            ra_nxt     = in_data;
            resync_nxt = 1'b1;
            state_nxt  = S_B;
          end else begin
            a_nxt         = ra;
            b_nxt         = rb;
            c_nxt         = in_data;
            out_valid_nxt = 1'b1;
            state_nxt     = S_A;
          end
        end
      end
      default: state_nxt = S_A;
    endcase

    if (tmo_fire) begin
      state_nxt   = S_A;
      ra_nxt      = '0;
      rb_nxt      = '0;
      timeout_nxt = 1'b1;
    end

    // Idle counter: cleared outside a partial triple and on every beat, frozen under stall.
    if ((TIMEOUT == 0) || (state == S_A) || in_beat || tmo_fire) begin
      tcnt_nxt = '0;
    end else if (in_ready && (tcnt != TW'(TIMEOUT))) begin
      tcnt_nxt = tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_A;
      ra           <= '0;
      rb           <= '0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      out_valid    <= 1'b0;
      err_resync   <= 1'b0;
      err_timeout  <= 1'b0;
      triple_count <= '0;
      tcnt         <= '0;
    end else begin
      state        <= state_nxt;
      ra           <= ra_nxt;
      rb           <= rb_nxt;
      a            <= a_nxt;
      b            <= b_nxt;
      c            <= c_nxt;
      out_valid    <= out_valid_nxt;
      err_resync   <= resync_nxt;
      err_timeout  <= timeout_nxt;
      triple_count <= count_nxt;
      tcnt         <= tcnt_nxt;
    end
  end

endmodule
